// File: rtl/announcer_glyph_mapper.sv
// Announcer glyph mapper: countdown sequencer, manual glyph override and 2-stage palette lookup.
// Optional run-time palette writes are enabled with `define ANNOUNCER_PAL_WR_EN.
//
// state     | meaning
// ST_IDLE   | no sequence running; manual glyph may be shown
// ST_SHOW   | countdown running, cur_glyph displayed for HOLD_FRAMES ticks each
// ST_DONE   | countdown finished; manual glyph may be shown, start restarts
module announcer_glyph_mapper #(
  parameter int N_GLYPHS    = 5,
  parameter int SEQ_LEN     = 4,
  parameter int HOLD_FRAMES = 60,
  parameter int COLOR_BITS  = 3,
  parameter int ADDR_W      = 19,
  parameter int GSEL_W      = 3
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  pix_req,
  input  logic [ADDR_W-1:0]     pix_addr,
  output logic [ADDR_W-1:0]     rom_addr,
  output logic [GSEL_W-1:0]     rom_glyph,
  input  logic [COLOR_BITS-1:0] rom_data,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  frame_tick,
  input  logic                  man_en,
  input  logic [GSEL_W-1:0]     man_glyph,
`ifdef ANNOUNCER_PAL_WR_EN
  input  logic                  pal_we,
  input  logic [COLOR_BITS-1:0] pal_idx,
  input  logic [23:0]           pal_data,
`endif
  output logic [7:0]            Red,
  output logic [7:0]            Green,
  output logic [7:0]            Blue,
  output logic                  zero,
  output logic                  pix_valid,
  output logic                  seq_active,
  output logic                  seq_done,
  output logic [GSEL_W-1:0]     cur_glyph
);

  localparam int FC_W  = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int PAL_N = 1 << COLOR_BITS;
  localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(HOLD_FRAMES - 1);
  localparam logic [GSEL_W-1:0] SEQ_LAST  = GSEL_W'(SEQ_LEN - 1);
  localparam logic [GSEL_W:0]   N_GLYPH_W = (GSEL_W + 1)'(N_GLYPHS);

  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_DONE} state_t;

  function automatic logic [23:0] pal_default(input int idx);
    case (idx)
      0:       return 24'h272323;
      1:       return 24'hFFFFFF;
      2:       return 24'hF7A503;
      3:       return 24'h0B0B0B;
      4:       return 24'hDEEF00;
      5:       return 24'hE83000;
      6:       return 24'hF77B02;
      7:       return 24'hFFCF00;
      default: return 24'h000000;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [GSEL_W-1:0] cur_glyph_q, cur_glyph_d;
  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic              seq_done_q, seq_done_d;

  always_comb begin
    state_d     = state_q;
    cur_glyph_d = cur_glyph_q;
    frame_cnt_d = frame_cnt_q;
    seq_done_d  = 1'b0;
    if (abort) begin
      state_d     = ST_IDLE;
      cur_glyph_d = '0;
      frame_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d     = ST_SHOW;
            cur_glyph_d = '0;
            frame_cnt_d = '0;
          end
        end
        ST_SHOW: begin
          if (frame_tick) begin
            if (frame_cnt_q == FC_LAST) begin
              frame_cnt_d = '0;
              if (cur_glyph_q == SEQ_LAST) begin
                state_d    = ST_DONE;
                seq_done_d = 1'b1;
              end else begin
                cur_glyph_d = cur_glyph_q + GSEL_W'(1);
              end
            end else begin
              frame_cnt_d = frame_cnt_q + FC_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      cur_glyph_q <= '0;
      frame_cnt_q <= '0;
      seq_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_glyph_q <= cur_glyph_d;
      frame_cnt_q <= frame_cnt_d;
      seq_done_q  <= seq_done_d;
    end
  end

  // Out-of-range manual glyphs blank the display rather than address past the ROM.
  logic man_ok;
  logic glyph_on;

  always_comb begin
    man_ok    = man_en && ({1'b0, man_glyph} < N_GLYPH_W);
    glyph_on  = 1'b0;
    rom_glyph = cur_glyph_q;
    if (state_q == ST_SHOW) begin
      glyph_on = 1'b1;
    end else if (man_ok) begin
      glyph_on  = 1'b1;
      rom_glyph = man_glyph;
    end
  end

  assign rom_addr = pix_addr;

  logic [23:0] pal_rd;

`ifdef ANNOUNCER_PAL_WR_EN
  logic [23:0] pal_q [PAL_N];
  logic [23:0] pal_d [PAL_N];

  always_comb begin
    for (int i = 0; i < PAL_N; i++) pal_d[i] = pal_q[i];
    if (pal_we) pal_d[pal_idx] = pal_data;
  end

  always_ff @(posedge Clk) begin
    for (int i = 0; i < PAL_N; i++) begin
      if (!Reset_n) pal_q[i] <= pal_default(i);
      else          pal_q[i] <= pal_d[i];
    end
  end

  // Reads the pre-write value so a same-edge lookup sees the old colour.
  assign pal_rd = pal_q[rom_data];
`else
  assign pal_rd = pal_default(int'(rom_data));
`endif

  logic        req1_q, req1_d;
  logic        on1_q, on1_d;
  logic        valid_q, valid_d;
  logic [23:0] rgb_q, rgb_d;
  logic        zero_q, zero_d;

  always_comb begin
    req1_d  = pix_req;
    on1_d   = glyph_on;
    valid_d = req1_q;
    rgb_d   = rgb_q;
    zero_d  = zero_q;
    if (req1_q) begin
      if (!on1_q || rom_data == '0) begin
        zero_d = 1'b1;
        rgb_d  = 24'hFFFFFF;
      end else begin
        zero_d = 1'b0;
        rgb_d  = pal_rd;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      req1_q  <= 1'b0;
      on1_q   <= 1'b0;
      valid_q <= 1'b0;
      rgb_q   <= 24'hFFFFFF;
      zero_q  <= 1'b1;
    end else begin
      req1_q  <= req1_d;
      on1_q   <= on1_d;
      valid_q <= valid_d;
      rgb_q   <= rgb_d;
      zero_q  <= zero_d;
    end
  end

  assign Red        = rgb_q[23:16];
  assign Green      = rgb_q[15:8];
  assign Blue       = rgb_q[7:0];
  assign zero       = zero_q;
  assign pix_valid  = valid_q;
  assign seq_active = (state_q == ST_SHOW);
  assign seq_done   = seq_done_q;
  assign cur_glyph  = cur_glyph_q;

endmodule

// File: doc/announcer_glyph_mapper.md
Name: announcer_glyph_mapper

Overview:
- Parametrised successor to the single-glyph letter colour mapper. Handles N_GLYPHS announcer glyphs (3, 2, 1, FIGHT, KO) through one external glyph ROM port.
- Contains a frame-counted sequencer that steps through the countdown automatically, plus a manual glyph override.
- Pipelined colour-code to RGB palette lookup with a transparency flag. Sits between the VGA pixel address generator and the colour mux.

Parameters:
N_GLYPHS, 5, number of glyph images in the ROM (index 0..N_GLYPHS-1)
SEQ_LEN, 4, glyphs 0..SEQ_LEN-1 form the auto countdown; must be <= N_GLYPHS
HOLD_FRAMES, 60, frame_tick pulses each sequenced glyph is shown; >= 1
COLOR_BITS, 3, colour-code width; palette depth 2**COLOR_BITS
ADDR_W, 19, pixel address width
GSEL_W, 3, glyph index width; 2**GSEL_W >= N_GLYPHS

Ports:
Clk  in  1  clock, all logic on posedge
Reset_n  in  1  synchronous, active-low reset
pix_req  in  1  pixel lookup request this cycle
pix_addr  in  ADDR_W  pixel address within glyph
rom_addr  out  ADDR_W  combinational copy of pix_addr
rom_glyph  out  GSEL_W  combinational current glyph index
rom_data  in  COLOR_BITS  ROM colour code, valid 1 cycle after rom_addr/rom_glyph
start  in  1  begin countdown sequence (pulse)
abort  in  1  return sequencer to IDLE
frame_tick  in  1  one-cycle pulse per frame
man_en  in  1  manual glyph display enable
man_glyph  in  GSEL_W  manual glyph index
Red  out  8  pixel red
Green  out  8  pixel green
Blue  out  8  pixel blue
zero  out  1  1 = transparent pixel
pix_valid  out  1  RGB/zero valid for the request issued 2 cycles earlier
seq_active  out  1  sequencer in SHOW
seq_done  out  1  one-cycle pulse on countdown completion
cur_glyph  out  GSEL_W  registered current glyph index

Behaviour:
- Reset (Reset_n=0 at posedge):
  - Red=Green=Blue=8'hFF, zero=1, pix_valid=0, seq_done=0, seq_active=0.
  - cur_glyph=0, frame_cnt=0, state IDLE. All pipeline valid bits cleared. Palette is restored to its defaults.
- Sequencer states and transitions:
  - IDLE --start--> SHOW: cur_glyph<=0, frame_cnt<=0.
  - DONE --start--> SHOW: same as from IDLE.
  - SHOW: each frame_tick increments frame_cnt. When frame_tick arrives with frame_cnt==HOLD_FRAMES-1:
    - frame_cnt<=0.
    - If cur_glyph==SEQ_LEN-1: go to DONE, pulse seq_done for 1 cycle.
    - Else: cur_glyph++.
  - start while in SHOW is ignored.
  - abort in any state: go to IDLE, cur_glyph<=0, frame_cnt<=0. abort beats start when both are asserted.
  - Reset mid-SHOW: go to IDLE and lose progress; no seq_done pulse.
- Display enable (glyph_on):
  - SHOW: on, with glyph = cur_glyph.
  - IDLE/DONE with man_en=1 and man_glyph<N_GLYPHS: on, with glyph = man_glyph. In this case rom_glyph=man_glyph and cur_glyph is unchanged.
  - Otherwise off.
- Pipeline (latency 2, fully pipelined, one request per cycle):
  - Cycle t: pix_req with pix_addr. rom_addr/rom_glyph are driven, and pix_req and glyph_on are registered.
  - Cycle t+1: rom_data arrives. The palette lookup is registered at the t+1->t+2 edge.
  - Cycle t+2: pix_valid=1 and outputs are updated.
  - No request: pix_valid=0 and RGB/zero hold their previous values.
  - Glyph changes take effect for requests issued after the change edge. In-flight pixels keep their stage-0 glyph_on.
- Colour mapping:
  - code 0, or glyph_on==0: zero=1, RGB=FF/FF/FF.
  - Otherwise: zero=0, RGB=palette[code][23:16]/[15:8]/[7:0].
- Palette defaults:
  - Entries 1..7: FFFFFF, F7A503, 0B0B0B, DEEF00, E83000, F77B02, FFCF00.
  - Entry 0 is 272323 but is never displayed.
  - Entries >=8 are 000000.

Optional Feature:
- Macro: ANNOUNCER_PAL_WR_EN.
- Defined:
  - Adds input ports pal_we (1), pal_idx (COLOR_BITS) and pal_data (24).
  - Palette entries are registers. A write lands at the posedge where pal_we=1.
  - A lookup at that same edge reading that index returns the old value.
  - Reset restores the defaults.
- Undefined: the ports are absent and the palette is constant defaults.

Test Plan:
- Reset then idle: pix_req=1, man_en=0, rom_data=5 -> 2 cycles later pix_valid=1, zero=1, RGB=FF/FF/FF.
- man_en=1, man_glyph=4: pix_req stream with rom_data=5 then 0 -> rom_glyph=4; outputs E8/30/00 zero=0, then FF/FF/FF zero=1, each at +2 cycles, back-to-back.
- HOLD_FRAMES=2, start: 8 frame_ticks -> cur_glyph 0,0,1,1,2,2,3,3 across the ticks. seq_done pulses exactly once on the 8th tick, then state DONE, seq_active=0.
- Mid-SHOW (cur_glyph=2): abort and start in the same cycle -> IDLE, cur_glyph=0, no seq_done. Then start alone -> SHOW from glyph 0.
- man_glyph=7 (>=N_GLYPHS) with man_en=1 -> zero=1 for all codes. start while in SHOW -> frame_cnt unchanged.
- ANNOUNCER_PAL_WR_EN: write idx 2 = 123456 in the same cycle as a code-2 lookup -> that pixel F7/A5/03, the next pixel 12/34/56. Reset -> F7/A5/03 again.
